// File: rtl/key_scan_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, debounce states
// and the column priority helper used to form key codes.
package key_scan_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } deb_state_t;

    // Index of the lowest set bit; callers only use the result when hits != 0.
    function automatic logic [1:0] lowest_col(input logic [KEY_COLS-1:0] hits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = KEY_COLS - 1; c >= 0; c--) begin
            if (hits[c]) idx = 2'(c);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_deb_fsm.sv
// Frame-level debounce: a code must repeat for DEB_FRAMES frames to be accepted,
// and must be absent for DEB_FRAMES frames to be released.
module key_deb_fsm
    import key_scan_pkg::*;
#(
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  logic       found,
    input  logic [3:0] code,
    output logic       key_sta,
    output logic [3:0] value,
    output logic       press_evt
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

    deb_state_t state;
    logic [3:0] cnt;
    logic [3:0] cand;
    logic       match;

    assign match = found && (code == cand);

    // Same-edge strobe so the interrupt latch sets together with key_sta.
    assign press_evt = frame_end && (state == PRESS_DEB) && match && (cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cand    <= 4'd0;
            key_sta <= 1'b0;
            value   <= 4'd0;
        end else if (frame_end) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cand  <= code;
                        cnt   <= 4'd1;
                        state <= PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (match) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == DEB_LAST) begin
                            state   <= HELD;
                            value   <= cand;
                            key_sta <= 1'b1;
                        end
                    end else if (found) begin
                        cand <= code;
                        cnt  <= 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HELD: begin
                    if (!match) begin
                        cnt   <= 4'd1;
                        state <= REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (match) begin
                        cnt   <= 4'd0;
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == DEB_LAST) begin
                            state   <= IDLE;
                            key_sta <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: row drive, column synchronizer, per-frame lowest-code
// capture, debounce and a latched press interrupt for the MCU key register block.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [3:0] key_row_o4,
    input  logic [3:0] key_col_i4,
    output logic [7:0] key_value_o8,
    output logic       key_sta_o,
    output logic       key_int_o,
    input  logic       key_clr_i
);

    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       col_s1;
    logic [3:0]       col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_cnt;
    logic             acc_found;
    logic [3:0]       acc_code;
    logic             sample;
    logic             frame_end;
    logic [3:0]       row_hit;
    logic             hit_now;
    logic [3:0]       hit_code;
    logic             frame_found;
    logic [3:0]       frame_code;
    logic             deb_sta;
    logic [3:0]       deb_value;
    logic             press_evt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= key_col_i4;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            row_cnt <= 2'd0;
        end else if (sample) begin
            div_cnt <= '0;
            row_cnt <= row_cnt + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign key_row_o4 = ~(4'b0001 << row_cnt);
    assign sample     = (div_cnt == DIV_LAST);
    assign frame_end  = sample && (row_cnt == 2'd3);

    assign row_hit  = ~col_s2;
    assign hit_now  = |row_hit;
    assign hit_code = {row_cnt, lowest_col(row_hit)};

    // Rows are scanned in ascending order, so the first hit of a frame is its lowest code.
    assign frame_found = acc_found || hit_now;
    assign frame_code  = acc_found ? acc_code : hit_code;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
        end else if (frame_end) begin
            acc_found <= 1'b0;
        end else if (sample && hit_now && !acc_found) begin
            acc_found <= 1'b1;
            acc_code  <= hit_code;
        end
    end

    key_deb_fsm #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_deb (
        .clk      (clk_i),
        .rst      (rst_i),
        .frame_end(frame_end),
        .found    (frame_found),
        .code     (frame_code),
        .key_sta  (deb_sta),
        .value    (deb_value),
        .press_evt(press_evt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_int_o <= 1'b0;
        end else if (key_clr_i) begin
            key_int_o <= 1'b0;
        end else if (press_evt) begin
            key_int_o <= 1'b1;
        end
    end

    assign key_sta_o    = deb_sta;
    assign key_value_o8 = {4'h0, deb_value};

endmodule
